// File: rtl/load_align_extender_pkg.sv
// Shared constants, states and helpers for the load align/extend path.
// Optional two-beat misaligned loads: LOAD_MISALIGN_SPLIT_EN.
package load_align_extender_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WT0  = 3'd2,
    S_RD1  = 3'd3,
    S_WT1  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    unique case (f3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic [2:0] f3,
                                      input int xlen);
    return (f3 == 3'b111) ||
           (xlen == 32 && (f3 == F3_LD || f3 == F3_LWU));
  endfunction

endpackage

// File: rtl/load_align_extender_extend.sv
// Combinational byte alignment and sign/zero extension of load beats.
// Also applies W-op sign extension to pass-through results.
module load_data_extender
  import load_align_extender_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  lo,
  input  logic [XLEN-1:0]  hi,
  input  logic             word_op,
  input  logic             is_load,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] sh;

  assign sh = XLEN'({hi, lo} >> {offset, 3'b000});

  always_comb begin
    result = sh;
    if (!is_load) begin
      result = lo;
      if (word_op && XLEN == 64)
        result = XLEN'(signed'(lo[31:0]));
    end else begin
      unique case (funct3)
        F3_LB:   result = XLEN'(signed'(sh[7:0]));
        F3_LH:   result = XLEN'(signed'(sh[15:0]));
        F3_LW:   result = XLEN'(signed'(sh[31:0]));
        F3_LBU:  result = XLEN'(sh[7:0]);
        F3_LHU:  result = XLEN'(sh[15:0]);
        F3_LWU:  result = XLEN'(sh[31:0]);
        default: result = sh;
      endcase
    end
  end

endmodule

// File: rtl/load_align_extender.sv
// Load path FSM: aligned reads, beat capture, result handshake.
// LOAD_MISALIGN_SPLIT_EN builds the second-beat RD1/WT1 path.
module load_align_extender
  import load_align_extender_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_word_op,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              out_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  state_t            state, state_n;
  logic [2:0]        f3_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] base_q;
  logic [XLEN-1:0]   data_q;
  logic              fault_q;
`ifdef LOAD_MISALIGN_SPLIT_EN
  logic              span_q;
  logic [XLEN-1:0]   lo_q;
`endif

  logic             accept;
  logic             span;
  logic             bad;
  logic [OFF_W-1:0] in_off;
  logic [4:0]       reach;
  logic [XLEN-1:0]  ext_lo;
  logic [XLEN-1:0]  ext_hi;
  logic [XLEN-1:0]  ext_res;

  assign accept = in_valid && in_ready;
  assign in_off = in_addr[OFF_W-1:0];
  assign reach  = 5'(in_off) + 5'(size_of(in_funct3));
  assign span   = reach > 5'(NB);

`ifdef LOAD_MISALIGN_SPLIT_EN
  assign bad    = illegal_f3(in_funct3, XLEN);
  assign ext_lo = (state == S_IDLE) ? in_data :
                  (state == S_WT1)  ? lo_q : mem_resp_data;
  assign ext_hi = (state == S_WT1) ? mem_resp_data : '0;
`else
  assign bad    = illegal_f3(in_funct3, XLEN) || span;
  assign ext_lo = (state == S_IDLE) ? in_data : mem_resp_data;
  assign ext_hi = '0;
`endif

  load_data_extender #(.XLEN(XLEN)) u_ext (
    .funct3  (f3_q),
    .offset  (off_q),
    .lo      (ext_lo),
    .hi      (ext_hi),
    .word_op (in_word_op),
    .is_load (state != S_IDLE),
    .result  (ext_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept)
                state_n = (!in_is_load || bad) ? S_OUT : S_RD0;
      S_RD0:  if (mem_req_ready) state_n = S_WT0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      S_WT0:  if (mem_resp_valid)
                state_n = span_q ? S_RD1 : S_OUT;
      S_RD1:  if (mem_req_ready) state_n = S_WT1;
      S_WT1:  if (mem_resp_valid) state_n = S_OUT;
`else
      S_WT0:  if (mem_resp_valid) state_n = S_OUT;
`endif
      S_OUT:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state == S_IDLE);
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    out_valid     = (state == S_OUT);
    out_data      = data_q;
    out_fault     = fault_q;
    if (state == S_RD0) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = base_q;
    end
    if (state == S_RD1) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = base_q + ADDR_W'(NB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q    <= '0;
      off_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      span_q  <= 1'b0;
      lo_q    <= '0;
`endif
    end else begin
      if (accept) begin
        f3_q   <= in_funct3;
        off_q  <= in_off;
        base_q <= {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
`ifdef LOAD_MISALIGN_SPLIT_EN
        span_q <= span;
`endif
        if (!in_is_load || bad) begin
          data_q  <= in_is_load ? '0 : ext_res;
          fault_q <= in_is_load;
        end
      end
      // single-beat result; a spanning load overwrites it in WT1
      if (state == S_WT0 && mem_resp_valid) begin
        data_q  <= ext_res;
        fault_q <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
        lo_q    <= mem_resp_data;
`endif
      end
`ifdef LOAD_MISALIGN_SPLIT_EN
      if (state == S_WT1 && mem_resp_valid)
        data_q <= ext_res;
`endif
    end
  end

endmodule

// File: tb/tb_load_align_extender.sv
// Directed bench for load_align_extender with a byte-level result model.
// Honours LOAD_MISALIGN_SPLIT_EN to pick the expected build behaviour.
module tb_load_align_extender;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 32;
`ifdef LOAD_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_is_load = 1'b0;
  logic              in_word_op = 1'b0;
  logic [2:0]        in_funct3 = 3'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [XLEN-1:0]   in_data = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b1;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid = 1'b0;
  logic [XLEN-1:0]   mem_resp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [XLEN-1:0]   out_data;
  logic              out_fault;

  always #5 clk = ~clk;

  load_align_extender #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_is_load     (in_is_load),
    .in_word_op     (in_word_op),
    .in_funct3      (in_funct3),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_fault      (out_fault)
  );

  typedef struct {
    logic [63:0] data;
    logic        fault;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [63:0] resp_q[$];
  logic [31:0] req_log[$];
  bit          resp_en = 1'b1;
  bit          resp_pend = 1'b0;
  bit          stray = 1'b0;
  int          stall_cnt = 0;
  logic [63:0] last_data = '0;
  logic        last_fault = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, want);
    end
  endtask

  function automatic bit spans(input logic [2:0] f3,
                               input logic [31:0] addr);
    return int'(addr[2:0]) + (1 << f3[1:0]) > 8;
  endfunction

  function automatic bit faults(input logic [2:0] f3,
                                input logic [31:0] addr);
    return f3 == 3'b111 || (spans(f3, addr) && !SPLIT);
  endfunction

  // Result built byte by byte from the memory image {hi, lo}.
  function automatic exp_t model(input bit is_load, input bit word_op,
                                 input logic [2:0] f3,
                                 input logic [31:0] addr,
                                 input logic [63:0] data,
                                 input logic [63:0] lo,
                                 input logic [63:0] hi);
    exp_t e;
    int size, off;
    logic [63:0] v;
    logic [7:0] b;
    e.fault = 1'b0;
    e.data  = data;
    if (!is_load) begin
      if (word_op) e.data = {{32{data[31]}}, data[31:0]};
      return e;
    end
    if (faults(f3, addr)) begin
      e.fault = 1'b1;
      e.data  = '0;
      return e;
    end
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    v    = '0;
    for (int i = 0; i < size; i++) begin
      int k = off + i;
      b = (k < 8) ? lo[8*k +: 8] : hi[8*(k-8) +: 8];
      v = v | (64'(b) << (8 * i));
    end
    if (!f3[2] && size < 8 && v[8*size-1])
      v = v | (~64'h0 << (8 * size));
    e.data = v;
    return e;
  endfunction

  // Memory: accepts per mem_req_ready, answers one cycle later.
  always @(negedge clk) begin
    mem_resp_valid = resp_pend || stray;
    mem_resp_data  = '0;
    if (stray)
      mem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    else if (resp_pend && resp_q.size() > 0)
      mem_resp_data = resp_q.pop_front();
    stray = 1'b0;
    mem_req_ready = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
    resp_pend = resp_en && rst_n && mem_req_valid && mem_req_ready;
    if (resp_pend) req_log.push_back(mem_req_addr);
  end

  // Every cycle with a result on the bus is checked against the model.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_valid 1, want 0");
      end else begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_fault", 64'(out_fault), 64'(exp_q[0].fault));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (out_ready) begin
          last_data  = out_data;
          last_fault = out_fault;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input bit is_load, input bit word_op,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] data, input logic [63:0] lo,
                      input logic [63:0] hi);
    int w = 0;
    @(negedge clk);
    #1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    in_is_load = is_load;
    in_word_op = word_op;
    in_funct3  = f3;
    in_addr    = addr;
    in_data    = data;
    exp_q.push_back(model(is_load, word_op, f3, addr, data, lo, hi));
    if (is_load && !faults(f3, addr)) begin
      resp_q.push_back(lo);
      if (spans(f3, addr)) resp_q.push_back(hi);
    end
    @(negedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_timeout: got out_valid 0, want 1");
    end
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run(input string name, input bit is_load,
                     input bit word_op, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] data,
                     input logic [63:0] lo, input logic [63:0] hi,
                     input int want_lat);
    int lat;
    req_log.delete();
    send(is_load, word_op, f3, addr, data, lo, hi);
    wait_out(lat);
    chk({name, "_lat"}, 64'(lat), 64'(want_lat));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_fault", 64'(out_fault), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    run("wop", 0, 1, 3'b000, 0, 64'h0000_0000_8000_0001, 0, 0, 1);
    chk("wop_lit", last_data, 64'hFFFF_FFFF_8000_0001);
    run("pass", 0, 0, 3'b000, 0, 64'h8000_0000_8000_0001, 0, 0, 1);
    chk("pass_lit", last_data, 64'h8000_0000_8000_0001);

    run("lb", 1, 0, 3'b000, 32'h1003, 0,
        64'h1122_3344_8566_7788, 0, 3);
    chk("lb_lit", last_data, 64'hFFFF_FFFF_FFFF_FF85);
    chk("lb_nreq", 64'(req_log.size()), 64'd1);
    foreach (req_log[i]) chk("lb_addr", 64'(req_log[i]), 64'h1000);

    run("lhu", 1, 0, 3'b101, 32'h2006, 0,
        64'hBEEF_0000_0000_0000, 0, 3);
    chk("lhu_lit", last_data, 64'h0000_0000_0000_BEEF);
    chk("lhu_fault", 64'(last_fault), 64'd0);

    run("lw_split", 1, 0, 3'b010, 32'h0006, 0,
        64'h2211_0000_0000_0000, 64'h0000_0000_0000_0080,
        SPLIT ? 5 : 1);
    chk("lw_split_lit", last_data, SPLIT ? 64'h0080_2211 : 64'h0);
    chk("lw_split_fault", 64'(last_fault), SPLIT ? 64'd0 : 64'd1);
    chk("lw_split_nreq", 64'(req_log.size()), SPLIT ? 64'd2 : 64'd0);
    foreach (req_log[i])
      chk("lw_split_addr", 64'(req_log[i]), 64'(i * 8));

    run("wrap", 1, 0, 3'b010, 32'hFFFF_FFFE, 0,
        64'hBBAA_0000_0000_0000, 64'h0000_0000_0000_DDCC,
        SPLIT ? 5 : 1);
    chk("wrap_lit", last_data,
        SPLIT ? 64'hFFFF_FFFF_DDCC_BBAA : 64'h0);
    chk("wrap_nreq", 64'(req_log.size()), SPLIT ? 64'd2 : 64'd0);
    foreach (req_log[i])
      chk("wrap_addr", 64'(req_log[i]),
          64'(32'(32'hFFFF_FFF8 + i * 8)));

    run("ld", 1, 0, 3'b011, 32'h3008, 0,
        64'hCAFE_BABE_1234_5678, 0, 3);
    chk("ld_lit", last_data, 64'hCAFE_BABE_1234_5678);

    run("ill", 1, 0, 3'b111, 32'h0010, 0, 0, 0, 1);
    chk("ill_fault", 64'(last_fault), 64'd1);
    chk("ill_lit", last_data, 64'd0);
    chk("ill_nreq", 64'(req_log.size()), 64'd0);

    run("lwu", 1, 0, 3'b110, 32'h4004, 0,
        64'h89AB_CDEF_0000_0000, 0, 3);
    chk("lwu_lit", last_data, 64'h0000_0000_89AB_CDEF);
    run("lw", 1, 0, 3'b010, 32'h4004, 0,
        64'h89AB_CDEF_0000_0000, 0, 3);
    chk("lw_lit", last_data, 64'hFFFF_FFFF_89AB_CDEF);
    run("lh", 1, 0, 3'b001, 32'h5006, 0,
        64'h8001_0000_0000_0000, 0, 3);
    chk("lh_lit", last_data, 64'hFFFF_FFFF_FFFF_8001);
    run("ld_mis", 1, 0, 3'b011, 32'h0011, 0,
        64'h8877_6655_4433_2211, 64'h0000_0000_0000_00FF,
        SPLIT ? 5 : 1);
    chk("ld_mis_lit", last_data,
        SPLIT ? 64'hFF88_7766_5544_3322 : 64'h0);

    // Memory stalls: request must hold steady until accepted.
    @(negedge clk);
    #1 stall_cnt = 3;
    send(1, 0, 3'b100, 32'h6005, 0, 64'h0000_A500_0000_0000, 0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
      chk("stall_req_addr", 64'(mem_req_addr), 64'h6000);
      @(negedge clk);
      #1;
    end
    wait_out(lat);
    drain();
    chk("stall_lit", last_data, 64'h0000_0000_0000_00A5);

    // Write-back backpressure.
    out_ready = 1'b0;
    send(1, 0, 3'b000, 32'h7000, 0, 64'h0000_0000_0000_007F, 0);
    wait_out(lat);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_release", 64'(in_ready), 64'd1);
    chk("bp_lit", last_data, 64'h0000_0000_0000_007F);

    // Reset while waiting for the first beat.
    resp_en = 1'b0;
    send(1, 0, 3'b010, 32'h8000, 0, 64'h1, 0);
    @(negedge clk);
    #1;
    chk("wt0_req_valid", 64'(mem_req_valid), 64'd0);
    chk("wt0_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("mid_rst_req_addr", 64'(mem_req_addr), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_out_fault", 64'(out_fault), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    resp_q.delete();
    resp_en = 1'b1;
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stray_out_valid", 64'(out_valid), 64'd0);
      chk("stray_req_valid", 64'(mem_req_valid), 64'd0);
      chk("stray_in_ready", 64'(in_ready), 64'd1);
    end
    run("post_rst", 1, 0, 3'b000, 32'h1003, 0,
        64'h1122_3344_8566_7788, 0, 3);
    chk("post_rst_lit", last_data, 64'hFFFF_FFFF_FFFF_FF85);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
